spi_slave_responder: RTL

SPI mode-0 target (responder) that answers the SoC's SPI master (`spi1`) across the flash/GPIO pin set, used for board loop-back and as a simulation flash stand-in. It oversamples `sclk`, `cs_n` and `mosi` in the `clk_i` domain and shifts bytes MSB-first. Received bytes go into an RX FIFO and transmitted bytes come from a TX FIFO. A simple host-side strobe interface lets a local controller or testbench exchange data, and sticky status flags report overrun and underrun.

---
 rtl/spi_slave_pkg.sv | 8 +
 rtl/spi_byte_fifo.sv | 62 ++++++
 rtl/spi_slave_responder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI responder slice.
package spi_slave_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} spi_slv_state_t;

  localparam int SPI_BYTE_W = 8;

endpackage

// File: rtl/spi_byte_fifo.sv
// Single-clock byte FIFO with registered full/empty flags and a
// combinational head read. Pointers carry one extra bit for wrap detection.
module spi_byte_fifo
  import spi_slave_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_n,
  input  logic                  i_push,
  input  logic [SPI_BYTE_W-1:0] i_wdata,
  input  logic                  i_pop,
  output logic [SPI_BYTE_W-1:0] o_rdata,
  output logic                  o_empty,
  output logic                  o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [SPI_BYTE_W-1:0] r_mem [DEPTH];
  logic [AW:0]           r_wr_ptr, r_rd_ptr, w_wr_ptr_n, w_rd_ptr_n;
  logic                  r_empty, r_full, w_push_ok, w_pop_ok;

  // A push into a full FIFO is accepted only when a pop frees the slot the
  // same cycle; a pop of an empty FIFO is ignored, so push-only on empty.
  always_comb begin
    w_pop_ok   = i_pop && !r_empty;
    w_push_ok  = i_push && (!r_full || w_pop_ok);
    w_wr_ptr_n = w_push_ok ? r_wr_ptr + (AW+1)'(1) : r_wr_ptr;
    w_rd_ptr_n = w_pop_ok  ? r_rd_ptr + (AW+1)'(1) : r_rd_ptr;
  end

  // Pointer and flag registers; flags derive from the next pointers.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_n;
      r_rd_ptr <= w_rd_ptr_n;
      r_empty  <= (w_wr_ptr_n == w_rd_ptr_n);
      r_full   <= (w_wr_ptr_n[AW] != w_rd_ptr_n[AW]) &&
                  (w_wr_ptr_n[AW-1:0] == w_rd_ptr_n[AW-1:0]);
    end
  end

  // Storage array, cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = r_empty;
  assign o_full  = r_full;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 responder: oversampled SPI pins, MSB-first shifting, RX/TX
// byte FIFOs with a host strobe interface and sticky overrun/underrun flags.
module spi_slave_responder
  import spi_slave_pkg::*;
#(
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE  = 8'hFF
) (
  input  logic                  clk_i,
  input  logic                  reset_n,
  input  logic                  sclk_i,
  input  logic                  cs_n_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic                  miso_oe_o,
  input  logic [SPI_BYTE_W-1:0] tx_wdata_i,
  input  logic                  tx_we_i,
  input  logic                  rx_re_i,
  output logic [SPI_BYTE_W-1:0] rx_rdata_o,
  output logic                  rx_empty_o,
  output logic                  rx_full_o,
  output logic                  tx_empty_o,
  output logic                  tx_full_o,
  output logic                  rx_ovr_o,
  output logic                  tx_udr_o,
  input  logic                  flag_clr_i,
  output logic                  byte_done_o
);

  localparam int CNT_W = $clog2(SPI_BYTE_W);

  spi_slv_state_t        r_state, w_state_n;
  logic [2:0]            r_sclk_sync, r_cs_sync;
  logic [1:0]            r_mosi_sync;
  logic [SPI_BYTE_W-1:0] r_tx_sr, w_tx_sr_n, r_rx_sr, w_rx_sr_n;
  logic [SPI_BYTE_W-1:0] w_rx_byte, w_tx_next, w_tx_rdata;
  logic [CNT_W-1:0]      r_bit_cnt, w_bit_cnt_n;
  logic                  r_reload, w_reload_n, r_oe, w_oe_n;
  logic                  w_tx_pop, w_rx_push, w_udr_set, w_ovr_set;
  logic                  r_byte_done, r_rx_ovr, r_tx_udr;
  logic                  w_sclk_rise, w_sclk_fall, w_cs_assert, w_cs_deassert;
  logic                  w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;

  // Two-flop synchronizers; the third flop on sclk/cs feeds edge detection.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], sclk_i};
      r_cs_sync   <= {r_cs_sync[1:0], cs_n_i};
      r_mosi_sync <= {r_mosi_sync[0], mosi_i};
    end
  end

  assign w_sclk_rise   =  r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_sclk_fall   = ~r_sclk_sync[1] &  r_sclk_sync[2];
  assign w_cs_assert   = ~r_cs_sync[1]   &  r_cs_sync[2];
  assign w_cs_deassert =  r_cs_sync[1]   & ~r_cs_sync[2];
  assign w_rx_byte     = {r_rx_sr[SPI_BYTE_W-2:0], r_mosi_sync[1]};
  assign w_tx_next     = w_tx_empty ? IDLE_BYTE : w_tx_rdata;

  // The TX load happens on the cs-assert cycle itself so MISO is valid three
  // clocks after cs_n falls; LOAD is then a single settling cycle.
  always_comb begin
    w_state_n   = r_state;
    w_tx_sr_n   = r_tx_sr;
    w_rx_sr_n   = r_rx_sr;
    w_bit_cnt_n = r_bit_cnt;
    w_reload_n  = r_reload;
    w_oe_n      = r_oe;
    w_tx_pop    = 1'b0;
    w_rx_push   = 1'b0;
    w_udr_set   = 1'b0;
    if (w_cs_deassert) begin
      w_state_n   = IDLE;
      w_oe_n      = 1'b0;
      w_bit_cnt_n = '0;
      w_reload_n  = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (w_cs_assert) begin
          w_state_n   = LOAD;
          w_tx_sr_n   = w_tx_next;
          w_tx_pop    = !w_tx_empty;
          w_udr_set   = w_tx_empty;
          w_bit_cnt_n = '0;
          w_reload_n  = 1'b0;
          w_oe_n      = 1'b1;
        end
        LOAD: w_state_n = SHIFT;
        SHIFT: begin
          if (w_sclk_rise) begin
            w_rx_sr_n   = w_rx_byte;
            w_bit_cnt_n = r_bit_cnt + CNT_W'(1);
            if (r_bit_cnt == CNT_W'(SPI_BYTE_W - 1)) begin
              w_rx_push   = 1'b1;
              w_reload_n  = 1'b1;
              w_bit_cnt_n = '0;
            end
          end else if (w_sclk_fall) begin
            if (r_reload) begin
              w_tx_sr_n  = w_tx_next;
              w_tx_pop   = !w_tx_empty;
              w_udr_set  = w_tx_empty;
              w_reload_n = 1'b0;
            end else begin
              w_tx_sr_n = {r_tx_sr[SPI_BYTE_W-2:0], 1'b0};
            end
          end
        end
        default: w_state_n = IDLE;
      endcase
    end
  end

  // A full RX FIFO drops the byte unless the host pops in the same cycle.
  assign w_ovr_set = w_rx_push & w_rx_full & ~rx_re_i;

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_n;
  end

  // Shift datapath, completion pulse and sticky flags (set beats clear).
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_sr     <= '0;
      r_rx_sr     <= '0;
      r_bit_cnt   <= '0;
      r_reload    <= 1'b0;
      r_oe        <= 1'b0;
      r_byte_done <= 1'b0;
      r_rx_ovr    <= 1'b0;
      r_tx_udr    <= 1'b0;
    end else begin
      r_tx_sr     <= w_tx_sr_n;
      r_rx_sr     <= w_rx_sr_n;
      r_bit_cnt   <= w_bit_cnt_n;
      r_reload    <= w_reload_n;
      r_oe        <= w_oe_n;
      r_byte_done <= w_rx_push;
      r_rx_ovr    <= w_ovr_set | (r_rx_ovr & ~flag_clr_i);
      r_tx_udr    <= w_udr_set | (r_tx_udr & ~flag_clr_i);
    end
  end

  spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (clk_i),
    .reset_n (reset_n),
    .i_push  (tx_we_i),
    .i_wdata (tx_wdata_i),
    .i_pop   (w_tx_pop),
    .o_rdata (w_tx_rdata),
    .o_empty (w_tx_empty),
    .o_full  (w_tx_full)
  );

  spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (clk_i),
    .reset_n (reset_n),
    .i_push  (w_rx_push),
    .i_wdata (w_rx_byte),
    .i_pop   (rx_re_i),
    .o_rdata (rx_rdata_o),
    .o_empty (w_rx_empty),
    .o_full  (w_rx_full)
  );

  assign miso_o      = r_oe ? r_tx_sr[SPI_BYTE_W-1] : 1'b1;
  assign miso_oe_o   = r_oe;
  assign rx_empty_o  = w_rx_empty;
  assign rx_full_o   = w_rx_full;
  assign tx_empty_o  = w_tx_empty;
  assign tx_full_o   = w_tx_full;
  assign rx_ovr_o    = r_rx_ovr;
  assign tx_udr_o    = r_tx_udr;
  assign byte_done_o = r_byte_done;

endmodule
